// File: rtl/stego_pkg.sv
// Shared types and constants for the 2-bit LSB stego extraction scheduler.
package stego_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

    localparam int LEN_W_DEF     = 24;
    localparam int HDR_SYMS      = LEN_W_DEF / 2;
    localparam int SYMS_PER_BYTE = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Right-shifting Galois LFSR step.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/stego_rr_arbiter.sv
// Round-robin selector: first requester at or after (last_winner+1) mod N_REQ, one-hot.
module stego_rr_arbiter
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_winner,
    input  logic                     enable,
    output logic [N_REQ-1:0]         grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_winner) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stego_decode_sched.sv
// Arbitrated header/payload controller for the 2-bit LSB stego extraction path.
// Define STEGO_SCHED_XOR_DESCRAMBLE_EN to XOR each payload byte with an LFSR keystream.
module stego_decode_sched
    import stego_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LEN_W        = LEN_W_DEF,
    parameter int MAX_LEN_BITS = 2097152
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     src_valid,
    input  logic [8*N_REQ-1:0]   src_data,
    output logic [N_REQ-1:0]     src_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    input  logic                 abort,
    output logic                 busy,
    output logic [LEN_W-1:0]     msg_len,
    output logic                 done,
    output logic                 err_len
);

    localparam int IW    = $clog2(N_REQ);
    localparam int HDR_N = LEN_W / 2;
    localparam int HW    = $clog2(HDR_N + 1);
    localparam logic [LEN_W:0]   MAX_L = (LEN_W+1)'(MAX_LEN_BITS);
    localparam logic [LEN_W-1:0] TWO   = LEN_W'(2);

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   grant_q, arb_grant;
    logic [IW-1:0]      gidx, arb_idx, last_winner;
    logic [HW-1:0]      hdr_cnt;
    logic [LEN_W-1:0]   remaining, rem_sub, len_new;
    logic [1:0]         slot, sym, sym_eff;
    logic [7:0]         asm_q, asm_nxt, out_byte;
    logic               xfer, hdr_last, too_long, would_complete, slot_full;
    logic               unused_src;

    assign unused_src = ^src_data;
    assign grant      = grant_q;
    assign busy       = (state != IDLE);

    stego_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req         (req),
        .last_winner (last_winner),
        .enable      (state == IDLE),
        .grant       (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_grant[i]) arb_idx = IW'(i);
    end

    always_comb begin
        sym = 2'b00;
        for (int i = 0; i < N_REQ; i++)
            if (gidx == IW'(i)) sym = src_data[8*i +: 2];
    end

    assign hdr_last       = (hdr_cnt == HW'(1));
    assign len_new        = {msg_len[LEN_W-3:0], sym};
    assign too_long       = {1'b0, len_new} > MAX_L;
    // An odd trailing bit uses only the symbol's upper bit.
    assign sym_eff        = (remaining == LEN_W'(1)) ? {sym[1], 1'b0} : sym;
    assign rem_sub        = (remaining >= TWO) ? remaining - TWO : '0;
    assign slot_full      = (slot == 2'(SYMS_PER_BYTE - 1));
    assign would_complete = slot_full || (remaining <= TWO);

    always_comb begin
        asm_nxt = asm_q;
        case (slot)
            2'd0:    asm_nxt = {sym_eff, asm_q[5:0]};
            2'd1:    asm_nxt = {asm_q[7:6], sym_eff, asm_q[3:0]};
            2'd2:    asm_nxt = {asm_q[7:4], sym_eff, asm_q[1:0]};
            default: asm_nxt = {asm_q[7:2], sym_eff};
        endcase
    end

`ifdef STEGO_SCHED_XOR_DESCRAMBLE_EN
    logic [7:0] lfsr;
    assign out_byte = asm_nxt ^ lfsr;
`else
    assign out_byte = asm_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        src_ready = '0;
        case (state)
            HDR:     src_ready = grant_q;
            PAYLOAD: if (remaining != '0 && !(would_complete && out_valid && !out_ready))
                         src_ready = grant_q;
            default: ;
        endcase
        if (abort && state != IDLE) src_ready = '0;
        xfer = |(src_valid & src_ready);

        case (state)
            IDLE:    if (|req) state_nxt = HDR;
            HDR:     if (xfer && hdr_last) begin
                         if (len_new == '0)  state_nxt = DONE;
                         else if (too_long)  state_nxt = IDLE;
                         else                state_nxt = PAYLOAD;
                     end
            PAYLOAD: if (out_valid && out_ready && out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    // last_winner resets to N_REQ-1 so the first search starts at index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q     <= '0;
            gidx        <= '0;
            last_winner <= IW'(N_REQ - 1);
            hdr_cnt     <= '0;
            msg_len     <= '0;
            remaining   <= '0;
            slot        <= '0;
            asm_q       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            err_len     <= 1'b0;
`ifdef STEGO_SCHED_XOR_DESCRAMBLE_EN
            lfsr        <= LFSR_SEED;
`endif
        end else begin
            done    <= 1'b0;
            err_len <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                IDLE: if (|req) begin
                    grant_q <= arb_grant;
                    gidx    <= arb_idx;
                    hdr_cnt <= HW'(HDR_N);
                end
                HDR: if (xfer) begin
                    msg_len <= len_new;
                    hdr_cnt <= hdr_cnt - 1'b1;
                    if (hdr_last && len_new != '0) begin
                        if (too_long) begin
                            err_len     <= 1'b1;
                            grant_q     <= '0;
                            last_winner <= gidx;
                        end else begin
                            remaining <= len_new;
                            slot      <= '0;
                            asm_q     <= '0;
`ifdef STEGO_SCHED_XOR_DESCRAMBLE_EN
                            lfsr      <= LFSR_SEED;
`endif
                        end
                    end
                end
                PAYLOAD: if (xfer) begin
                    remaining <= rem_sub;
                    if (slot_full || rem_sub == '0) begin
                        out_data  <= out_byte;
                        out_valid <= 1'b1;
                        out_last  <= (rem_sub == '0);
                        asm_q     <= '0;
                        slot      <= '0;
`ifdef STEGO_SCHED_XOR_DESCRAMBLE_EN
                        lfsr      <= lfsr_step(lfsr);
`endif
                    end else begin
                        asm_q <= asm_nxt;
                        slot  <= slot + 2'd1;
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    grant_q     <= '0;
                    last_winner <= gidx;
                end
                default: ;
            endcase
            if (abort && state != IDLE) begin
                out_valid   <= 1'b0;
                out_last    <= 1'b0;
                grant_q     <= '0;
                last_winner <= gidx;
                done        <= 1'b0;
                err_len     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stego_decode_sched.sv
// Directed-vector bench for stego_decode_sched with two symbol-queue sources and a sink log.
module tb_stego_decode_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, src_valid, src_ready, grant;
    logic [15:0] src_data;
    logic        out_valid, out_last, out_ready, abort, busy, done, err_len;
    logic [7:0]  out_data;
    logic [23:0] msg_len;

    always #5 clk = ~clk;

    stego_decode_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .abort     (abort),
        .busy      (busy),
        .msg_len   (msg_len),
        .done      (done),
        .err_len   (err_len)
    );

    int         n_vec = 0, n_bad = 0;
    logic [1:0] q0[$], q1[$];
    logic [7:0] rx_d[$];
    logic       rx_l[$];
    int         glog[$];
    int         xc0 = 0, xc1 = 0, n_done = 0, n_errp = 0;
    logic [1:0] acc, prev_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_sym(input int s, input logic [1:0] v);
        if (s == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic push_hdr(input int s, input logic [23:0] len);
        for (int k = 0; k < 12; k++) push_sym(s, len[22-2*k +: 2]);
    endtask

    task automatic push_pay(input int s, input logic [79:0] pay, input int nsym);
        for (int k = 0; k < nsym; k++) push_sym(s, pay[78-2*k +: 2]);
    endtask

    task automatic wait_pulse(input string tag, input bit want_err, input int maxcyc);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < maxcyc) begin
            @(negedge clk);
            n++;
            hit = want_err ? err_len : done;
        end
        chk({tag, "_seen"}, 32'(hit), 1);
    endtask

    task automatic chk_rx(input string tag, input logic [31:0] bytes, input logic [3:0] lasts, input int n);
        chk({tag, "_nbytes"}, rx_d.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < rx_d.size()) ? 32'(rx_d[i]) : 32'hDEAD, 32'(bytes[8*(n-1-i) +: 8]));
            chk($sformatf("%s_last%0d", tag, i), (i < rx_l.size()) ? 32'(rx_l[i]) : 32'hDEAD, 32'(lasts[i]));
        end
        rx_d.delete();
        rx_l.delete();
    endtask

    function automatic int gl(input int i);
        return (i < glog.size()) ? glog[i] : 99;
    endfunction

    // Sources, sink and pulse monitor: sample just before the edge, update just after it.
    initial begin
        src_valid  = '0;
        src_data   = '0;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            #2;
            acc = src_valid & src_ready;
            if (out_valid && out_ready) begin
                rx_d.push_back(out_data);
                rx_l.push_back(out_last);
            end
            if (done)    n_done++;
            if (err_len) n_errp++;
            if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant[1] ? 1 : 0);
            prev_grant = grant;
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() > 0) begin q0.delete(0); xc0++; end
            if (acc[1] && q1.size() > 0) begin q1.delete(0); xc1++; end
            src_valid[0]   = (q0.size() > 0);
            src_valid[1]   = (q1.size() > 0);
            src_data[7:0]  = (q0.size() > 0) ? {6'h2A, q0[0]} : 8'h00;
            src_data[15:8] = (q1.size() > 0) ? {6'h15, q1[0]} : 8'h00;
        end
    end

    initial begin
        int n, x0, bad;
        logic [7:0] d0;
        reset = 1'b1; req = '0; out_ready = 1'b1; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_len", msg_len, 0);
        chk("rst_srdy", src_ready, 0);
        reset = 1'b0;
        @(negedge clk);

        // len 16 on source 0
        push_hdr(0, 24'd16);
        push_pay(0, {8'h6C, 8'hF1, 64'h0}, 8);
        req = 2'b01;
        wait_pulse("t1", 0, 200);
        req = 2'b00;
        chk("t1_grant_clr", grant, 0);
        @(negedge clk);
        chk("t1_done_width", done, 0);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_len", msg_len, 16);
        chk("t1_xfers", xc0, 20);
        chk_rx("t1", 32'h6CF1, 4'b0010, 2);

        // len 10 and odd len 9 on source 1
        push_hdr(1, 24'd10);
        push_pay(1, {8'hFF, 8'h80, 64'h0}, 5);
        req = 2'b10;
        wait_pulse("t2", 0, 200);
        req = 2'b00;
        @(negedge clk);
        chk("t2_xfers", xc1, 17);
        chk_rx("t2", 32'hFF80, 4'b0010, 2);
        push_hdr(1, 24'd9);
        push_pay(1, {8'hFF, 8'hC0, 64'h0}, 5);
        req = 2'b10;
        wait_pulse("t2b", 0, 200);
        req = 2'b00;
        @(negedge clk);
        chk("t2b_xfers", xc1, 34);
        chk("t2b_len", msg_len, 9);
        chk_rx("t2b", 32'hFF80, 4'b0010, 2);

        // round robin with both requesting
        glog.delete();
        push_hdr(0, 24'd8); push_pay(0, {8'hA5, 72'h0}, 4);
        push_hdr(0, 24'd8); push_pay(0, {8'h3C, 72'h0}, 4);
        push_hdr(1, 24'd8); push_pay(1, {8'h5A, 72'h0}, 4);
        req = 2'b11;
        wait_pulse("t3a", 0, 200);
        wait_pulse("t3b", 0, 200);
        wait_pulse("t3c", 0, 200);
        req = 2'b00;
        @(negedge clk);
        chk("t3_ngrants", glog.size(), 3);
        chk("t3_g0", gl(0), 0);
        chk("t3_g1", gl(1), 1);
        chk("t3_g2", gl(2), 0);
        chk("t3_done_cnt", n_done, 6);
        chk_rx("t3", 32'hA55A3C, 4'b0111, 3);

        // sink stall mid-payload
        out_ready = 1'b0;
        x0 = xc0;
        push_hdr(0, 24'd32);
        push_pay(0, {32'hDEADBEEF, 48'h0}, 16);
        req = 2'b01;
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("t4_oval", out_valid, 1);
        d0 = out_data;
        chk("t4_first", d0, 8'hDE);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== d0 || out_valid !== 1'b1) bad++;
        end
        chk("t4_hold", bad, 0);
        chk("t4_srdy", src_ready, 0);
        chk("t4_xfers", xc0 - x0, 19);
        out_ready = 1'b1;
        wait_pulse("t4", 0, 200);
        req = 2'b00;
        @(negedge clk);
        chk_rx("t4", 32'hDEADBEEF, 4'b1000, 4);

        // oversize length on source 1, zero length on source 0
        glog.delete();
        push_hdr(1, 24'h3FFFFF);
        push_hdr(0, 24'd0);
        req = 2'b11;
        wait_pulse("t5_err", 1, 200);
        req = 2'b01;
        chk("t5_len_bad", msg_len, 24'h3FFFFF);
        chk("t5_grant_clr", grant, 0);
        wait_pulse("t5_zero", 0, 200);
        req = 2'b00;
        chk("t5_len_zero", msg_len, 0);
        @(negedge clk);
        chk("t5_g0", gl(0), 1);
        chk("t5_g1", gl(1), 0);
        chk("t5_err_cnt", n_errp, 1);
        chk("t5_done_cnt", n_done, 8);
        chk("t5_nbytes", rx_d.size(), 0);

        // abort at payload byte 3 of 10
        push_hdr(0, 24'd80);
        push_pay(0, 80'h0102030405060708090A, 40);
        req = 2'b01;
        n = 0;
        while (rx_d.size() < 2 && n < 300) begin @(negedge clk); n++; end
        chk("t6_reach", 32'(rx_d.size() >= 2), 1);
        abort = 1'b1;
        req = 2'b00;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_oval", out_valid, 0);
        chk("t6_grant", grant, 0);
        chk("t6_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", n_done, 8);
        chk("t6_byte0", (rx_d.size() > 0) ? 32'(rx_d[0]) : 32'hDEAD, 8'h01);
        chk("t6_byte1", (rx_d.size() > 1) ? 32'(rx_d[1]) : 32'hDEAD, 8'h02);
        q0.delete();
        rx_d.delete();
        rx_l.delete();
        glog.delete();
        push_hdr(0, 24'd0);
        push_hdr(1, 24'd0);
        req = 2'b11;
        wait_pulse("t6_pa", 0, 200);
        req = 2'b01;
        wait_pulse("t6_pb", 0, 200);
        req = 2'b00;
        @(negedge clk);
        chk("t6_prio0", gl(0), 1);
        chk("t6_prio1", gl(1), 0);

        // asynchronous reset mid-header
        x0 = xc0;
        push_hdr(0, 24'h1FFFFE);
        req = 2'b01;
        n = 0;
        while (xc0 - x0 < 4 && n < 100) begin @(negedge clk); n++; end
        chk("t7_busy", busy, 1);
        chk("t7_partial", 32'(msg_len != 0), 1);
        #3 reset = 1'b1;
        #1;
        chk("t7_rst_outs", {grant, src_ready, busy, out_valid, out_last, done, err_len, out_data}, 0);
        chk("t7_rst_len", msg_len, 0);
        req = 2'b00;
        q0.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t7_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stego_decode_sched.md
Name: stego_decode_sched

Overview:
- Controller and arbiter for the 2-bit LSB stego extraction datapath.
- Shares one extraction path between N_REQ pixel-byte sources, granting one source for a whole message: header, then payload.
- Parses the length header, assembles payload bytes MSB-first, and drives a valid/ready output toward the downstream sink.
- Reports per-message completion and length errors.

Parameters:
- N_REQ, 2, number of pixel-byte sources; must be 2..8.
- LEN_W, 24, header length field width in bits; must be even.
- MAX_LEN_BITS, 2097152, largest accepted payload length in bits.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  source i has a message pending.
- src_valid  input  N_REQ  source i byte valid.
- src_data  input  8*N_REQ  source i pixel byte; only bits [1:0] are used.
- src_ready  output  N_REQ  byte accepted from source i; asserted only on the granted index.
- grant  output  N_REQ  one-hot owner of the datapath; all zero when idle.
- out_valid  output  1  payload byte valid.
- out_data  output  8  payload byte.
- out_last  output  1  final byte of the message; qualified by out_valid.
- out_ready  input  1  sink accepts out_data.
- abort  input  1  synchronous cancel of the current message.
- busy  output  1  state != IDLE.
- msg_len  output  LEN_W  parsed length in bits; held until the next header starts.
- done  output  1  one-cycle pulse on normal message completion.
- err_len  output  1  one-cycle pulse when a length is rejected.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer at index 0.
- A byte transfer on source g occurs when src_valid[g] && src_ready[g]. One 2-bit symbol, data[1:0], is taken per transfer.
- IDLE:
  - If any req bit is set, grant the first requester at or after (last_winner+1) mod N_REQ.
  - grant is registered, so it is visible the cycle after the request is seen. Go to HDR.
- HDR:
  - src_ready[g] = 1.
  - Shift LEN_W/2 symbols (12 by default) into msg_len, MSB first.
  - When the last symbol is taken:
    - len == 0 -> DONE, no output.
    - len > MAX_LEN_BITS -> err_len pulse, then IDLE.
    - otherwise -> PAYLOAD with remaining = len.
- PAYLOAD:
  - Symbols fill a 4-slot assembler, MSB first.
  - A byte completes after 4 symbols, or earlier when remaining reaches 0; unused low bits are zero-padded.
  - The completed byte loads out_data, and out_valid rises the next cycle.
  - Each symbol decrements remaining by 2. Odd len: the final symbol contributes only its bit [1] and remaining goes to 0.
  - out_last = 1 on the byte that completes with remaining == 0.
  - src_ready[g] = 0 when the next symbol would complete a byte while out_valid && !out_ready. No symbol is ever dropped or duplicated.
  - After the out_last byte is accepted -> DONE.
- DONE: pulse done for one cycle, clear grant, record last_winner = g, go to IDLE. A new grant can be issued the next cycle.
- Output rule: out_valid/out_data/out_last hold stable until out_ready.
- req deassertion mid-message is ignored; the grant is held until DONE, error or abort.
- abort: highest priority in any non-IDLE state.
  - Next cycle: state IDLE, out_valid = 0, grant = 0.
  - No done pulse. last_winner is updated, so the aborted source loses priority.
- Simultaneous abort and final handshake: abort wins and done is not pulsed.
- Reset mid-message returns everything to reset values. The partial message is lost.
- Width rules:
  - remaining is LEN_W bits.
  - The payload byte count is ceil(len/8), computed as (len+7)>>3 with no overflow at MAX_LEN_BITS.

Optional Feature:
- STEGO_SCHED_XOR_DESCRAMBLE_EN defined:
  - Each payload byte is XORed with the state of an 8-bit Galois LFSR (taps 0xB8) before loading out_data.
  - The LFSR is seeded to 8'hA5 at each PAYLOAD entry and steps once per output byte loaded.
  - Padding bits are XORed too.
- Not defined: out_data is the raw assembled byte and no LFSR logic exists.

Decomposition:
- Package stego_pkg holds:
  - state typedef {IDLE, HDR, PAYLOAD, DONE};
  - LEN_W default, HDR_SYMS = LEN_W/2, SYMS_PER_BYTE = 4;
  - LFSR seed and taps constants.
- Sub-module stego_rr_arbiter (N_REQ; inputs req, last_winner, enable; output one-hot grant) holds the round-robin selection.

Test Plan:
- Single message on source 0, header len = 16, payload symbols 01,10,11,00,11,11,00,01 -> two bytes 0x6C then 0xF1, out_last on 0xF1, done pulse, grant back to 0.
- Length 10 bits, symbols 11,11,11,11,10 -> bytes 0xFF then 0x80 with out_last; exactly 17 transfers counted (12 header + 5 payload).
- req = 2'b11 held for three messages -> grants in order source 0, source 1, source 0, each with len = 8 and one byte out.
- out_ready held low for 20 cycles mid-payload -> src_ready drops, out_data stable, no lost symbols; byte sequence matches golden after release.
- Header len = 0x3FFFFF (> MAX_LEN_BITS) -> err_len pulse, no out_valid, next requester granted; len = 0 -> done pulse with no output bytes.
- abort asserted at payload byte 3 of 10 -> out_valid low and grant zero the next cycle, no done pulse. Then asynchronous reset mid-header -> all outputs 0.
